debug_uart_sched: RTL

//  Transmit scheduler for the 4 Mbaud debug UART transmitter (uart_tx instance).

---
 rtl/debug_uart_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/debug_uart_sched.sv
// debug_uart_sched: transmit scheduler for the debug UART transmitter.
// Buffers CPU byte writes in a small FIFO and launches them on uart_tx,
// optionally sharing the transmitter round-robin with a hardware trace source.
// Optional feature macro: DEBUG_UART_SCHED_TRACE_EN (trace source arbitration).
module debug_uart_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_wr_en,
    input  logic [7:0]       cpu_wr_data,
    output logic             cpu_full,
    output logic [LVL_W-1:0] cpu_level,
    output logic             overflow,
    input  logic             overflow_clr,
    input  logic             trace_req,
    input  logic [7:0]       trace_data,
    output logic             trace_ack,
    output logic             uart_tx_en,
    output logic [7:0]       uart_tx_data,
    input  logic             uart_tx_busy,
    output logic             idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             guard, guard_nxt;
    logic             fifo_empty, pop, push, drop, grant_trace;
    logic [7:0]       load_data;

`ifdef DEBUG_UART_SCHED_TRACE_EN
    typedef enum logic {SRC_CPU, SRC_TRACE} src_t;
    src_t last_grant;

    assign load_data = grant_trace ? trace_data : mem[rd_ptr];

    // Remember the last granted source so a tie goes to the other one
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              last_grant <= SRC_TRACE;
        else if (pop)         last_grant <= SRC_CPU;
        else if (grant_trace) last_grant <= SRC_TRACE;
    end
`else
    logic unused_trace;
    assign unused_trace = ^{trace_req, trace_data};
    assign load_data    = mem[rd_ptr];
`endif

    assign fifo_empty = (count == '0);
    assign cpu_full   = (count == FULL_LVL);
    assign cpu_level  = count;
    // A push into a full FIFO is still accepted when the head leaves this cycle
    assign push       = cpu_wr_en && (!cpu_full || pop);
    assign drop       = cpu_wr_en && cpu_full && !pop;
    assign trace_ack  = grant_trace;
    assign idle       = (state == IDLE) && fifo_empty;

    // FIFO storage; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cpu_wr_data;
    end

    // FIFO pointers/count, sticky overflow and the transmit data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
            if (pop || grant_trace) uart_tx_data <= load_data;
        end
    end

    // FSM state register and start-timeout guard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            guard <= 1'b0;
        end else begin
            state <= state_nxt;
            guard <= guard_nxt;
        end
    end

    // Arbitration, next-state and strobe decode
    always_comb begin
        state_nxt   = state;
        guard_nxt   = guard;
        pop         = 1'b0;
        grant_trace = 1'b0;
        uart_tx_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!uart_tx_busy) begin
`ifdef DEBUG_UART_SCHED_TRACE_EN
                    if (!fifo_empty && (!trace_req || last_grant == SRC_TRACE)) pop = 1'b1;
                    else if (trace_req) grant_trace = 1'b1;
`else
                    pop = !fifo_empty;
`endif
                end
                if (pop || grant_trace) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                uart_tx_en = 1'b1;
                guard_nxt  = 1'b0;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Two cycles without busy means the start was missed
                if (uart_tx_busy) state_nxt = WAIT_DONE;
                else if (guard)   state_nxt = IDLE;
                else              guard_nxt = 1'b1;
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
